// File: rtl/skew_feeder_pkg.sv
// Shared types and elaboration-time helpers for the skew feeder.
//   clog2_min1 : ceil(log2(n)), never less than 1 bit
//   t_end      : index of the last step of one streamed block
//   state_e    : top-level FSM encoding
package skew_feeder_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Width needed to hold values 0..n-1, at least one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

    // Last step: the most-delayed lane finishes its data and flush zeros.
    function automatic int unsigned t_end(input int unsigned lanes,
                                          input int unsigned k,
                                          input int unsigned flush);
        return (lanes - 1) + k + flush - 1;
    endfunction

endpackage

// File: rtl/skew_feeder_lane.sv
// One output lane of the skew feeder.
//   en      : top FSM is streaming; otherwise the lane drives zero/invalid
//   t, d_l  : current step and this lane's fixed delay
//   words   : the lane's K-word slice of the active block
//   stall   : hold data/valid unchanged
//   data    : registered lane word
//   valid   : registered lane valid
module skew_lane #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned NUM_ELEMENTS = 6,
    parameter int unsigned FLUSH_ZEROS  = 6,
    parameter int unsigned TW           = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic [TW-1:0]                      t,
    input  logic [TW-1:0]                      d_l,
    input  logic [NUM_ELEMENTS*DATA_WIDTH-1:0] words,
    input  logic                               stall,
    output logic [DATA_WIDTH-1:0]              data,
    output logic                               valid
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic [TW-1:0]         j;

    // Step t maps to word j = t - d_l; words, then flush zeros, then idle.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        j       = '0;
        if (!stall) begin
            data_d  = '0;
            valid_d = 1'b0;
            if (en && (t >= d_l)) begin
                j = t - d_l;
                for (int unsigned e = 0; e < NUM_ELEMENTS; e++) begin
                    if (32'(j) == e) begin
                        data_d  = words[e*DATA_WIDTH +: DATA_WIDTH];
                        valid_d = 1'b1;
                    end
                end
                if ((32'(j) >= NUM_ELEMENTS) && (32'(j) < NUM_ELEMENTS + FLUSH_ZEROS)) begin
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/skew_feeder.sv
// Double-buffered multi-lane skewed feeder for the systolic array.
//   load_valid/load_ready/load_data : block handshake into the shadow buffer
//   stall                           : freeze streaming state and outputs
//   out_data/out_valid              : per-lane skewed word stream
//   busy                            : streaming or shadow holding a block
//   done                            : pulse aligned with the last step's output
// load_ready is registered (= shadow empty after the edge). A block can then
// never be offered in the same cycle as a shadow->active swap, so there is
// no combinational path from any input to load_ready.
module skew_feeder
    import skew_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned NUM_ELEMENTS = 6,
    parameter int unsigned NUM_LANES    = 4,
    parameter int unsigned FLUSH_ZEROS  = 6,
    parameter int unsigned SKEW_DESC    = 0
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          load_valid,
    output logic                                          load_ready,
    input  logic [NUM_LANES*NUM_ELEMENTS*DATA_WIDTH-1:0]  load_data,
    input  logic                                          stall,
    output logic [NUM_LANES*DATA_WIDTH-1:0]               out_data,
    output logic [NUM_LANES-1:0]                          out_valid,
    output logic                                          busy,
    output logic                                          done
);

    localparam int unsigned LANE_W = NUM_ELEMENTS * DATA_WIDTH;
    localparam int unsigned BLK_W  = NUM_LANES * LANE_W;
    localparam int unsigned T_END  = t_end(NUM_LANES, NUM_ELEMENTS, FLUSH_ZEROS);
    localparam int unsigned TW     = clog2_min1(T_END + 1);

    state_e             state_q, state_d;
    logic [TW-1:0]      t_q, t_d;
    logic [BLK_W-1:0]   active_q, active_d;
    logic [BLK_W-1:0]   shadow_q, shadow_d;
    logic               shadow_full_q, shadow_full_d;
    logic               done_q, done_d;
    logic               load_ready_q, load_ready_d;
    logic               busy_q, busy_d;
    logic               swap;

    // Step sequencing, shadow->active swap and load capture.
    always_comb begin
        state_d       = state_q;
        t_d           = t_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        done_d        = done_q;
        swap          = 1'b0;

        if (!stall) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    swap = shadow_full_q;
                end
                STREAM: begin
                    if (t_q == TW'(T_END)) begin
                        done_d = 1'b1;
                        if (shadow_full_q) begin
                            swap = 1'b1;
                        end else begin
                            state_d = IDLE;
                            t_d     = '0;
                        end
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase

            if (swap) begin
                active_d      = shadow_q;
                shadow_full_d = 1'b0;
                t_d           = '0;
                state_d       = STREAM;
            end
        end

        // Loads land in the shadow even while stalled.
        if (load_valid && load_ready_q) begin
            shadow_d      = load_data;
            shadow_full_d = 1'b1;
        end

        load_ready_d = !shadow_full_d;
        busy_d       = (state_d == STREAM) || shadow_full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            t_q           <= '0;
            active_q      <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            done_q        <= 1'b0;
            load_ready_q  <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            t_q           <= t_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            done_q        <= done_d;
            load_ready_q  <= load_ready_d;
            busy_q        <= busy_d;
        end
    end

    // One lane per row/column, each with its own fixed delay.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        localparam int unsigned DL = (SKEW_DESC != 0) ? (NUM_LANES - 1 - unsigned'(l))
                                                      : unsigned'(l);
        skew_lane #(
            .DATA_WIDTH   (DATA_WIDTH),
            .NUM_ELEMENTS (NUM_ELEMENTS),
            .FLUSH_ZEROS  (FLUSH_ZEROS),
            .TW           (TW)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (state_q == STREAM),
            .t     (t_q),
            .d_l   (TW'(DL)),
            .words (active_q[l*LANE_W +: LANE_W]),
            .stall (stall),
            .data  (out_data[l*DATA_WIDTH +: DATA_WIDTH]),
            .valid (out_valid[l])
        );
    end

    assign load_ready = load_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_skew_feeder.sv
// Bench for skew_feeder: three instances (ascending skew, descending skew,
// single-lane K=1 no-flush) compared every cycle against a block-queue model.
module tb_skew_feeder;

    typedef logic [127:0] blk_t;

    logic clk;
    logic rst_n;

    // Instances A (ascending) and B (descending) share stimulus.
    logic        lv_ab, st_ab;
    logic [95:0] ld_ab;
    logic [31:0] a_data, b_data;
    logic [1:0]  a_valid, b_valid;
    logic        a_ready, b_ready, a_busy, b_busy, a_done, b_done;

    logic        lv_c, st_c;
    logic [15:0] ld_c;
    logic [15:0] c_data;
    logic [0:0]  c_valid;
    logic        c_ready, c_busy, c_done;

    skew_feeder #(.DATA_WIDTH(16), .NUM_ELEMENTS(3), .NUM_LANES(2), .FLUSH_ZEROS(3), .SKEW_DESC(0)) u_a (
        .clk(clk), .rst_n(rst_n), .load_valid(lv_ab), .load_ready(a_ready), .load_data(ld_ab),
        .stall(st_ab), .out_data(a_data), .out_valid(a_valid), .busy(a_busy), .done(a_done));

    skew_feeder #(.DATA_WIDTH(16), .NUM_ELEMENTS(3), .NUM_LANES(2), .FLUSH_ZEROS(3), .SKEW_DESC(1)) u_b (
        .clk(clk), .rst_n(rst_n), .load_valid(lv_ab), .load_ready(b_ready), .load_data(ld_ab),
        .stall(st_ab), .out_data(b_data), .out_valid(b_valid), .busy(b_busy), .done(b_done));

    skew_feeder #(.DATA_WIDTH(16), .NUM_ELEMENTS(1), .NUM_LANES(1), .FLUSH_ZEROS(0), .SKEW_DESC(0)) u_c (
        .clk(clk), .rst_n(rst_n), .load_valid(lv_c), .load_ready(c_ready), .load_data(ld_c),
        .stall(st_c), .out_data(c_data), .out_valid(c_valid), .busy(c_busy), .done(c_done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_checks;

    // Model: per instance, the block being streamed, its step, one pending block.
    int unsigned p_l[3], p_k[3], p_f[3], p_s[3];
    bit          m_stream[3];
    int          m_step[3];
    blk_t        m_cur[3];
    bit          m_pfull[3];
    blk_t        m_pend[3];
    logic [31:0] e_data[3];
    logic [1:0]  e_valid[3];
    logic        e_done[3], e_ready[3], e_busy[3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_stream[i] = 1'b0;
            m_step[i]   = 0;
            m_cur[i]    = '0;
            m_pfull[i]  = 1'b0;
            m_pend[i]   = '0;
            e_data[i]   = '0;
            e_valid[i]  = '0;
            e_done[i]   = 1'b0;
            e_ready[i]  = 1'b1;
            e_busy[i]   = 1'b0;
        end
    endtask

    // Advance model i by one clock edge given the inputs seen at that edge.
    task automatic model_edge(input int i, input bit lv, input blk_t ld, input bit st);
        bit acc;
        int tend, k, f, d, j;
        acc  = lv && e_ready[i];
        k    = int'(p_k[i]);
        f    = int'(p_f[i]);
        tend = int'(p_l[i]) + k + f - 2;
        if (!st) begin
            e_data[i]  = '0;
            e_valid[i] = '0;
            e_done[i]  = 1'b0;
            if (m_stream[i]) begin
                for (int l = 0; l < int'(p_l[i]); l++) begin
                    d = (p_s[i] != 0) ? int'(p_l[i]) - 1 - l : l;
                    j = m_step[i] - d;
                    if (j >= 0 && j < k) begin
                        e_data[i][l*16 +: 16] = m_cur[i][(l*k + j)*16 +: 16];
                        e_valid[i][l] = 1'b1;
                    end else if (j >= k && j < k + f) begin
                        e_valid[i][l] = 1'b1;
                    end
                end
                e_done[i] = (m_step[i] == tend);
                if (m_step[i] == tend) begin
                    if (m_pfull[i]) begin
                        m_cur[i]   = m_pend[i];
                        m_pfull[i] = 1'b0;
                        m_step[i]  = 0;
                    end else begin
                        m_stream[i] = 1'b0;
                    end
                end else begin
                    m_step[i]++;
                end
            end else if (m_pfull[i]) begin
                m_cur[i]    = m_pend[i];
                m_pfull[i]  = 1'b0;
                m_step[i]   = 0;
                m_stream[i] = 1'b1;
            end
        end
        if (acc) begin
            m_pend[i]  = ld;
            m_pfull[i] = 1'b1;
        end
        e_ready[i] = !m_pfull[i];
        e_busy[i]  = m_stream[i] || m_pfull[i];
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) n_pass++;
        else $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, act, exp);
    endtask

    task automatic check_inst(input string n, input int i, input logic [31:0] d,
                              input logic [1:0] v, input logic dn, input logic rdy,
                              input logic bsy);
        check({n, ".out_data"},   d,         e_data[i]);
        check({n, ".out_valid"},  32'(v),    32'(e_valid[i]));
        check({n, ".done"},       32'(dn),   32'(e_done[i]));
        check({n, ".load_ready"}, 32'(rdy),  32'(e_ready[i]));
        check({n, ".busy"},       32'(bsy),  32'(e_busy[i]));
    endtask

    task automatic check_all();
        check_inst("A", 0, a_data, a_valid, a_done, a_ready, a_busy);
        check_inst("B", 1, b_data, b_valid, b_done, b_ready, b_busy);
        check_inst("C", 2, 32'(c_data), 2'(c_valid), c_done, c_ready, c_busy);
    endtask

    // One clock: model sees the same inputs as the DUTs, outputs sampled 1 later.
    task automatic cyc();
        @(posedge clk);
        model_edge(0, lv_ab, 128'(ld_ab), st_ab);
        model_edge(1, lv_ab, 128'(ld_ab), st_ab);
        model_edge(2, lv_c, 128'(ld_c), st_c);
        #1;
        check_all();
    endtask

    initial begin
        n_pass   = 0;
        n_checks = 0;
        p_l = '{2, 2, 1};
        p_k = '{3, 3, 1};
        p_f = '{3, 3, 0};
        p_s = '{0, 1, 0};
        rst_n = 1'b0;
        lv_ab = 1'b0; st_ab = 1'b0; ld_ab = '0;
        lv_c  = 1'b0; st_c  = 1'b0; ld_c  = '0;
        model_reset();

        // Reset state.
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Single block: lane0={1,2,3}, lane1={4,5,6}; C gets 0xBEEF.
        ld_ab = {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        lv_ab = 1'b1;
        ld_c  = 16'hBEEF;
        lv_c  = 1'b1;
        cyc();
        lv_ab = 1'b0;
        lv_c  = 1'b0;
        repeat (12) cyc();

        // Back-to-back: second block offered while the first is at step 2.
        ld_ab = {16'h16, 16'h15, 16'h14, 16'h13, 16'h12, 16'h11};
        lv_ab = 1'b1;
        cyc();
        lv_ab = 1'b0;
        repeat (3) cyc();
        ld_ab = {16'h26, 16'h25, 16'h24, 16'h23, 16'h22, 16'h21};
        lv_ab = 1'b1;
        cyc();
        lv_ab = 1'b0;
        repeat (20) cyc();

        // Stall for three cycles at step 2.
        ld_ab = {16'h36, 16'h35, 16'h34, 16'h33, 16'h32, 16'h31};
        lv_ab = 1'b1;
        cyc();
        lv_ab = 1'b0;
        repeat (3) cyc();
        st_ab = 1'b1;
        repeat (3) cyc();
        st_ab = 1'b0;
        repeat (12) cyc();

        // Asynchronous reset in the middle of a block.
        ld_ab = {16'h46, 16'h45, 16'h44, 16'h43, 16'h42, 16'h41};
        lv_ab = 1'b1;
        ld_c  = 16'h1234;
        lv_c  = 1'b1;
        cyc();
        lv_ab = 1'b0;
        lv_c  = 1'b0;
        repeat (5) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cyc();

        // Random loads, data and stalls.
        repeat (400) begin
            lv_ab = ($urandom % 3) == 0;
            ld_ab = {$urandom, $urandom, $urandom};
            st_ab = ($urandom % 5) == 0;
            lv_c  = ($urandom % 3) == 0;
            ld_c  = 16'($urandom);
            st_c  = ($urandom % 5) == 0;
            cyc();
        end
        lv_ab = 1'b0; st_ab = 1'b0;
        lv_c  = 1'b0; st_c  = 1'b0;
        repeat (20) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
